// File: rtl/serial_rx_sipo.sv
// Oversampling serial receiver: start/8 data (MSB first)/stop frames are
// recovered into a holding register with a valid/rd handshake and error flags.
module serial_rx_sipo #(
    parameter int OVERSAMPLE = 16,   // sample_en ticks per bit, even and >= 4
    parameter int DATA_BITS  = 8     // payload bits per frame, >= 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 serial_in,
    input  logic                 sample_en,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [1:0]           sync_reg;
    logic                 rx_s;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [BIT_W-1:0]     bitn_reg, bitn_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 busy_reg;
    logic                 load;

    logic [DATA_BITS-1:0] data_reg, data_next;
    logic                 valid_reg, valid_next;
    logic                 ferr_reg, ferr_next;
    logic                 oerr_reg, oerr_next;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], serial_in};
        end
    end

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bitn_reg  <= '0;
            shift_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bitn_reg  <= bitn_next;
            shift_reg <= shift_next;
            busy_reg  <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bitn_next  = bitn_reg;
        shift_next = shift_reg;
        load       = 1'b0;

        if (sample_en) begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        cnt_next   = '0;
                    end
                end
                START: begin
                    // Re-check the line half a bit later to reject glitches.
                    if (cnt_reg == CNT_HALF_LAST) begin
                        cnt_next = '0;
                        if (!rx_s) begin
                            state_next = DATA;
                            bitn_next  = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == CNT_FULL_LAST) begin
                        shift_next = {shift_reg[DATA_BITS-2:0], rx_s};
                        cnt_next   = '0;
                        bitn_next  = bitn_reg + 1'b1;
                        if (bitn_reg == BIT_LAST) begin
                            state_next = STOP;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    // Load at mid stop bit so back-to-back frames are not missed.
                    if (cnt_reg == CNT_FULL_LAST) begin
                        load       = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Holding register: a load always beats a simultaneous rd.
    always_comb begin
        data_next  = data_reg;
        valid_next = valid_reg;
        ferr_next  = ferr_reg;
        oerr_next  = oerr_reg;

        if (load) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            ferr_next  = ~rx_s;
            if (rd) begin
                oerr_next = 1'b0;
            end else if (valid_reg) begin
                oerr_next = 1'b1;
            end
        end else if (rd && valid_reg) begin
            valid_next = 1'b0;
            ferr_next  = 1'b0;
            oerr_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            oerr_reg  <= 1'b0;
        end else begin
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
            oerr_reg  <= oerr_next;
        end
    end

    assign data_out    = data_reg;
    assign data_valid  = valid_reg;
    assign framing_err = ferr_reg;
    assign overrun_err = oerr_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_serial_rx_sipo.sv
// Bench for serial_rx_sipo: frame table, multi-cycle corner sequences and
// random frames checked against a frame-level holding-register model.
module tb_serial_rx_sipo;

    localparam int OS = 16;
    localparam int DB = 8;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          serial_in = 1'b1;
    logic          sample_en = 1'b0;
    logic          rd        = 1'b0;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          framing_err;
    logic          overrun_err;
    logic          busy;

    int total = 0;
    int bad   = 0;

    int   tick_cnt        = 0;
    int   busy_rise_tick  = 0;
    int   busy_fall_tick  = 0;
    int   valid_rise_tick = 0;
    logic busy_prev       = 1'b0;
    logic valid_prev      = 1'b0;

    // Frame-level model of the holding register
    logic [7:0] m_data;
    logic       m_valid, m_fe, m_oe;

    typedef struct {
        logic [7:0] d;
        logic       stopb;
        logic       rd_load;
        logic       rd_after;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_fe;
        logic       exp_oe;
    } vec_t;

    vec_t vecs[6];

    serial_rx_sipo #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .serial_in   (serial_in),
        .sample_en   (sample_en),
        .rd          (rd),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // One tick every 4 clk
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 sample_en = 1'b1;
            @(posedge clk);
            #1 sample_en = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (sample_en) tick_cnt <= tick_cnt + 1;
    end

    always @(negedge clk) begin
        busy_prev  <= busy;
        valid_prev <= data_valid;
        if (busy && !busy_prev)        busy_rise_tick  <= tick_cnt;
        if (!busy && busy_prev)        busy_fall_tick  <= tick_cnt;
        if (data_valid && !valid_prev) valid_rise_tick <= tick_cnt;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        check({name, ".data"},  int'(data_out),    int'(m_data));
        check({name, ".valid"}, int'(data_valid),  int'(m_valid));
        check({name, ".fe"},    int'(framing_err), int'(m_fe));
        check({name, ".oe"},    int'(overrun_err), int'(m_oe));
    endtask

    function automatic void model_reset();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_fe    = 1'b0;
        m_oe    = 1'b0;
    endfunction

    function automatic void model_load(input logic [7:0] d, input logic stopb, input logic rd_on_load);
        if (rd_on_load)   m_oe = 1'b0;
        else if (m_valid) m_oe = 1'b1;
        m_valid = 1'b1;
        m_data  = d;
        m_fe    = ~stopb;
    endfunction

    function automatic void model_rd();
        if (m_valid) begin
            m_valid = 1'b0;
            m_fe    = 1'b0;
            m_oe    = 1'b0;
        end
    endfunction

    function automatic logic [9:0] frame_bits(input logic [7:0] d, input logic stopb);
        logic [9:0] b;
        b[0] = 1'b0;
        for (int j = 0; j < 8; j++) b[1+j] = d[7-j];
        b[9] = stopb;
        return b;
    endfunction

    // Returns 2 ns after the next clk edge on which sample_en is high
    task automatic wait_tick();
        do @(posedge clk); while (!sample_en);
        #2;
    endtask

    // Drives bits[k/OS] for each tick; optionally pulses rd on the load edge only
    task automatic send_bits(input logic [9:0] bits, input int nticks, input logic rd_load);
        for (int k = 0; k < nticks; k++) begin
            serial_in = bits[k / OS];
            if (rd_load && k == 152) begin
                wait (sample_en == 1'b1);
                rd = 1'b1;
            end
            wait_tick();
            if (rd_load && k == 152) rd = 1'b0;
        end
        serial_in = 1'b1;
    endtask

    task automatic do_rd();
        @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
        wait_tick();
    endtask

    task automatic print_txn(input string tag, input logic [7:0] d, input logic stopb);
        $display("%s: sent 0x%02h stop=%0b -> data_out=0x%02h valid=%0b fe=%0b oe=%0b busy=%0b",
                 tag, d, stopb, data_out, data_valid, framing_err, overrun_err, busy);
    endtask

    initial begin
        logic [7:0] rd_byte;
        logic       rstop;
        int         rmode;
        int         gap;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0};

        model_reset();

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        #2;
        check("rst.data",  int'(data_out),    0);
        check("rst.valid", int'(data_valid),  0);
        check("rst.fe",    int'(framing_err), 0);
        check("rst.oe",    int'(overrun_err), 0);
        check("rst.busy",  int'(busy),        0);
        #1 reset_n = 1'b1;
        wait_tick();

        // Idle line for 200 ticks: nothing may move
        for (int i = 0; i < 200; i++) begin
            wait_tick();
            check("idle", int'({data_out, data_valid, framing_err, overrun_err, busy}), 0);
        end
        $display("idle: 200 ticks, busy=%0b valid=%0b", busy, data_valid);

        // Table of frames
        for (int i = 0; i < 6; i++) begin
            send_bits(frame_bits(vecs[i].d, vecs[i].stopb), 160, vecs[i].rd_load);
            model_load(vecs[i].d, vecs[i].stopb, vecs[i].rd_load);
            print_txn($sformatf("table %0d", i), vecs[i].d, vecs[i].stopb);
            check($sformatf("tbl%0d.data", i),  int'(data_out),    int'(vecs[i].exp_data));
            check($sformatf("tbl%0d.valid", i), int'(data_valid),  int'(vecs[i].exp_valid));
            check($sformatf("tbl%0d.fe", i),    int'(framing_err), int'(vecs[i].exp_fe));
            check($sformatf("tbl%0d.oe", i),    int'(overrun_err), int'(vecs[i].exp_oe));
            if (i == 0) begin
                check("latency_ticks", valid_rise_tick - busy_rise_tick, 152);
            end
            if (vecs[i].rd_after) begin
                do_rd();
                model_rd();
                print_txn($sformatf("table %0d rd", i), vecs[i].d, vecs[i].stopb);
                check($sformatf("tbl%0d.rd.data", i),  int'(data_out),    int'(vecs[i].exp_data));
                check($sformatf("tbl%0d.rd.valid", i), int'(data_valid),  0);
                check($sformatf("tbl%0d.rd.fe", i),    int'(framing_err), 0);
                check($sformatf("tbl%0d.rd.oe", i),    int'(overrun_err), 0);
            end
        end

        // False start: line low for 4 ticks only
        serial_in = 1'b0;
        repeat (4) wait_tick();
        serial_in = 1'b1;
        repeat (20) wait_tick();
        $display("false start: busy pulse %0d ticks, valid=%0b", busy_fall_tick - busy_rise_tick, data_valid);
        check("false.busy_width", busy_fall_tick - busy_rise_tick, 8);
        check("false.valid",      int'(data_valid), 0);
        check("false.busy",       int'(busy),       0);
        check("false.data",       int'(data_out),   8'h22);

        // Asynchronous reset after 3 data bits of a frame
        send_bits(frame_bits(8'h5A, 1'b1), 64, 1'b0);
        check("abort.busy_before", int'(busy), 1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("abort.async_busy", int'(busy),     0);
        check("abort.async_data", int'(data_out), 0);
        model_reset();
        serial_in = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        wait_tick();
        for (int i = 0; i < 40; i++) begin
            wait_tick();
            check("abort.quiet", int'({data_valid, busy}), 0);
        end
        send_bits(frame_bits(8'h7E, 1'b1), 160, 1'b0);
        model_load(8'h7E, 1'b1, 1'b0);
        print_txn("after abort", 8'h7E, 1'b1);
        check_model("abort.next");

        // Random frames against the model
        for (int i = 0; i < 30; i++) begin
            rd_byte = 8'($urandom_range(0, 255));
            rstop   = ($urandom_range(0, 3) != 0);
            rmode   = $urandom_range(0, 2);
            gap     = $urandom_range(0, 40);
            send_bits(frame_bits(rd_byte, rstop), 160, rmode == 2);
            model_load(rd_byte, rstop, rmode == 2);
            print_txn($sformatf("rand %0d", i), rd_byte, rstop);
            check_model($sformatf("rand%0d", i));
            if (rmode == 1) begin
                do_rd();
                model_rd();
                check_model($sformatf("rand%0d.rd", i));
            end
            repeat (gap) wait_tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_rx_sipo.md
Name: serial_rx_sipo

Overview:
- Serial-in, parallel-out receive stage. It is the downstream consumer of the 10-bit serial frames produced by the transmit shift register.
- Frame on the line, in time order: start bit (0), D7..D6..D0 (MSB first), stop bit (1). Line idles high.
- Oversamples the line on a baud-multiple tick, recovers each byte, and presents it in a holding register with a valid/acknowledge handshake and error flags.

Parameters:
- OVERSAMPLE, 16, sample_en ticks per bit period; even, ≥4.
- DATA_BITS, 8, payload bits per frame.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- serial_in  input  1  asynchronous serial line, idle high.
- sample_en  input  1  one-clk strobe at OVERSAMPLE x baud rate; FSM advances only on cycles where it is high.
- rd  input  1  consumer acknowledge; clears valid and error flags.
- data_out  output  DATA_BITS  last received byte, held stable between loads.
- data_valid  output  1  holding register contains an unread byte.
- framing_err  output  1  last loaded byte had stop bit = 0.
- overrun_err  output  1  a byte was overwritten while unread; sticky.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Synchronizer flops = 1; FSM = IDLE; counters = 0; shift register = 0.
  - data_out = 0; data_valid = 0; framing_err = 0; overrun_err = 0; busy = 0.
- Input path: serial_in passes through a 2-flop synchronizer (clocked every clk). The FSM uses only the synchronized value rx_s.
- FSM states IDLE, START, DATA, STOP; tick counter cnt; bit counter bitn. All FSM transitions occur only on sample_en=1 cycles.
  - IDLE: rx_s=0 -> START, cnt=0.
  - START:
    - cnt increments each tick.
    - At cnt = OVERSAMPLE/2-1 (mid start bit): rx_s=0 -> DATA, cnt=0, bitn=0.
    - rx_s=1 at that point is a false start -> IDLE, with no flag.
  - DATA:
    - cnt increments each tick. At cnt = OVERSAMPLE-1 (mid-bit), shift rx_s into the shift register LSB, shifting earlier bits toward the MSB. The first data bit therefore ends in bit DATA_BITS-1.
    - Then cnt=0, bitn++. After bit DATA_BITS-1 is sampled -> STOP.
  - STOP: at cnt = OVERSAMPLE-1 (mid stop bit):
    - data_out <= shift register; data_valid <= 1; framing_err <= ~rx_s.
    - overrun_err <= 1 if data_valid=1 and rd=0 that cycle.
    - -> IDLE. There is no wait for the end of the stop bit, so back-to-back frames are accepted.
- Load latency: data_valid rises on the clk edge of the sample_en tick at mid stop bit. That is (OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE) ticks after the tick on which the start edge is seen in IDLE, plus 2 clk of synchronizer delay.
- Framing error: the byte is still loaded and data_valid still asserted; framing_err accompanies it.
- rd handling:
  - rd=1 with no simultaneous load: clears data_valid, framing_err and overrun_err next edge. data_out is held.
  - rd=1 on the same cycle as a load: the load wins. data_valid stays 1, framing_err takes the new value, overrun_err is cleared and not set.
  - rd with data_valid=0 has no effect.
- busy = (state != IDLE), registered with the state.
- Counter widths: cnt is $clog2(OVERSAMPLE) bits; bitn is $clog2(DATA_BITS+1) bits. Neither counter may wrap within a state.
- Reset mid-frame: asynchronous return to IDLE and all outputs to reset values. A partially received byte is discarded.
- serial_in changes between ticks have no effect except through rx_s at tick instants.

Test Plan:
- Reset, line idle high, sample_en every 4 clk for 200 ticks -> all outputs 0, busy=0 throughout.
- Send frame 0,1,0,1,0,0,1,0,1,1 (byte 0xA5, stop=1) at 16 ticks/bit -> data_out=0xA5, data_valid=1, framing_err=0, overrun_err=0. Check valid rises at the tick 152 after start detect. rd pulse -> data_valid=0, data_out still 0xA5.
- Line low for 4 ticks, then high -> FSM returns to IDLE at mid start bit; data_valid stays 0; busy pulses high for 8 ticks.
- Send 0x3C with stop bit 0 -> data_out=0x3C, data_valid=1, framing_err=1. rd -> both flags 0.
- Send 0x11 then back-to-back 0x22 with no rd -> data_out=0x22, data_valid=1, overrun_err=1. Repeat with rd asserted on the exact load cycle of 0x22 -> overrun_err=0, data_valid=1.
- Assert reset_n=0 mid-DATA of a frame (after 3 data bits), release, send 0x7E -> no spurious valid from the aborted frame; next valid shows 0x7E.
